mem: RTL and testbench
======================

# mem

Memory-access stage of the five-stage RISC-V pipeline, directly downstream of the execute stage. It consumes the execute stage's result, write-back target and 5-bit memory request, and performs loads and stores as byte-serial beats on the 8-bit memory port. It stalls upstream while a transfer is in flight and hands a registered result to write-back.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- res  in  32  execute result; the byte address for load/store.
- wa  in  5  write-back register address.
- we  in  1  write-back enable.
- e  in  5  memory request: bit4 enable, bits3:2 length−1 (0 byte, 1 half, 3 word), bit1 1=store/0=load, bit0 1=zero-extend.
- n  in  32  store data; the low bytes are used.
- gnt  in  1  memory port granted this cycle.
- mem_a  out  32  byte address.
- mem_dout  out  8  write byte.
- mem_wr  out  1  write strobe.
- mem_din  in  8  read byte, valid the cycle after its address.
- stall_req  out  1  holds the execute/memory latch and all upstream stages.
- res_o  out  32  write-back data, registered.
- wa_o  out  5  write-back address, registered.
- we_o  out  1  write-back enable, registered.

## Operation
- States: IDLE, BUSY, WAIT, DONE. All captures are in internal registers: addr, data, len, store, zext, wa, we, beat counter i, byte buffer.
- IDLE, e[4]=0:
  - Pass-through. At the edge: res_o←res, wa_o←wa, we_o←we.
  - stall_req=0.
- IDLE, e[4]=1:
  - stall_req=1.
  - At the edge: capture the request, set i=0, clear the buffer, set we_o=0, and go to BUSY.
- BUSY: beat i issues only when gnt=1.
  - mem_a=addr+i (32-bit wrap).
  - Store beat: mem_wr=1, mem_dout=data[8i+7:8i].
  - Load beat: mem_wr=0.
  - i increments on each issued beat.
  - After beat len is issued, a store goes to DONE and a load goes to WAIT.
  - With gnt=0: mem_wr=0, mem_a holds addr+i, no progress.
- Load capture:
  - A registered flag marks "read issued last cycle". While it is set, mem_din is written to buffer byte (i−1), whatever gnt is this cycle.
  - WAIT captures the final byte, then goes to DONE.
- Extension of the load result:
  - byte: sign from bit 7 unless zext.
  - half: sign from bit 15 unless zext.
  - word: unchanged.
  - len=2'b10: 3 beats, zero-extended from bit 23.
- DONE:
  - stall_req=0, so upstream advances at this edge.
  - The request inputs still hold the same instruction and are ignored.
  - At the edge: res_o←extended buffer for a load, or addr for a store; wa_o←wa; we_o←we & ~store. Then go to IDLE.
- In BUSY and WAIT, we_o=0 (bubble to write-back).
- mem_a and mem_dout are 0 when no beat is issued.
- Reset (asynchronous, also mid-transfer):
  - State→IDLE, counters and buffer cleared.
  - res_o=0, wa_o=0, we_o=0.
  - While rst is high: mem_wr=0, mem_a=0, mem_dout=0, stall_req=0.
  - A partial transfer is abandoned and is not resumed.

## Timing
- Non-memory instruction: result at the output 1 cycle after it is presented; no stall.
- N-byte store with gnt held high:
  - Beats in cycles 1..N after acceptance.
  - DONE in cycle N+1.
  - stall_req high for cycles 0..N (N+1 cycles).
- N-byte load with gnt held high:
  - Addresses in cycles 1..N, WAIT in N+1, DONE in N+2.
  - stall_req high for N+2 cycles.
- Each gnt=0 cycle in BUSY adds one cycle.
- Read data always arrives exactly one cycle after its address. A grant loss between beats never drops or duplicates a byte.
- stall_req is combinational from state and e[4]; the outputs are registered.

## Test plan
- Pass-through: e=0, res=0x1234, wa=5, we=1 → next cycle res_o=0x00001234, wa_o=5, we_o=1; stall_req=0 throughout.
- SW: addr 0x100, n=0xAABBCCDD, gnt=1:
  - mem_wr=1 on 0x100..0x103 with bytes DD, CC, BB, AA in consecutive cycles.
  - stall_req high 5 cycles; we_o=0 after DONE.
- Loads, each memory byte returned the cycle after its address:
  - LB at 0x200 reading 0x80 → res_o=0xFFFFFF80.
  - LBU reading 0x80 → 0x00000080.
  - LH reading 0x34, 0x92 → 0xFFFF9234.
  - LW reading 0x78, 0x56, 0x34, 0x12 → 0x12345678, with we_o=1 and wa_o preserved.
- LW with gnt low for 2 cycles after beat 1:
  - mem_a holds 0x..+1, mem_wr=0, no byte skipped.
  - stall_req lasts 8 cycles; result still correct.
- Async reset asserted mid-LW at beat 2:
  - Same cycle: mem_wr=0, stall_req=0; outputs 0.
  - After release, a new SB to 0x10 completes normally in 2 stall cycles.
- Wrap-around:
  - SH at 0xFFFFFFFE → writes 0xFFFFFFFE, 0xFFFFFFFF.
  - SW at 0xFFFFFFFF → writes 0xFFFFFFFF, 0x0, 0x1, 0x2.

Source files
------------

// File: rtl/mem_if.sv
// Byte-serial memory port between the memory-access stage and the memory.
//   mem_a    : byte address of the current beat (0 when no beat is issued)
//   mem_dout : write byte (0 unless a store beat is issued)
//   mem_wr   : write strobe
//   mem_din  : read byte, valid the cycle after its address
//   gnt      : the memory grants the port this cycle
// master = pipeline stage, slave = memory.
interface mem_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        gnt;

  modport master (input gnt, mem_din, output mem_a, mem_dout, mem_wr);
  modport slave  (output gnt, mem_din, input mem_a, mem_dout, mem_wr);
endinterface

// File: rtl/mem.sv
// Memory-access stage of the five-stage pipeline.
// Takes the execute result, write-back target and a 5-bit memory request,
// performs loads/stores as byte beats on an 8-bit port, stalls upstream while
// a transfer is in flight and presents a registered result to write-back.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   res             : execute result / byte address for load/store
//   wa, we          : write-back register address and enable
//   e               : {enable, length-1[1:0], store, zero-extend}
//   n               : store data (low bytes used)
//   bus             : byte-serial memory port (master side)
//   stall_req       : freeze execute/memory latch and upstream stages
//   res_o/wa_o/we_o : registered write-back data, address, enable
module mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] res,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [4:0]  e,
  input  logic [31:0] n,
  mem_if.master       bus,
  output logic        stall_req,
  output logic [31:0] res_o,
  output logic [4:0]  wa_o,
  output logic        we_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAIT, S_DONE} state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [1:0]  len_reg;
  logic        store_reg;
  logic        zext_reg;
  logic [4:0]  wa_reg;
  logic        we_reg;
  // Two bits suffice: after the last beat of a word it wraps to 0, and the
  // capture lane (i-1) still resolves to lane 3.
  logic [1:0]  i_reg;
  logic [31:0] buf_reg;
  logic        rd_pend_reg;   // a read address was issued last cycle

  logic        beat;
  logic [1:0]  cap_idx;
  logic [7:0]  data_bytes [4];
  logic [31:0] buf_next;
  logic [31:0] ext;

  assign beat    = (state_reg == S_BUSY) && bus.gnt;
  assign cap_idx = i_reg - 2'd1;

  // Byte lanes: store-data slicing and load-buffer capture.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign data_bytes[gi]     = data_reg[8*gi +: 8];
    assign buf_next[8*gi +: 8] = (rd_pend_reg && (cap_idx == 2'(gi))) ? bus.mem_din
                                                                       : buf_reg[8*gi +: 8];
  end

  // mem_a keeps pointing at the pending beat while the grant is withheld.
  assign bus.mem_a    = (state_reg == S_BUSY) ? addr_reg + {30'd0, i_reg} : 32'd0;
  assign bus.mem_wr   = beat && store_reg;
  assign bus.mem_dout = (beat && store_reg) ? data_bytes[i_reg] : 8'd0;

  // rst gating keeps stall low even while a request is presented during reset.
  assign stall_req = ~rst && (((state_reg == S_IDLE) && e[4]) ||
                              (state_reg == S_BUSY) || (state_reg == S_WAIT));

  always_comb begin
    ext = buf_reg;
    case (len_reg)
      2'd0:    ext = {{24{~zext_reg & buf_reg[7]}}, buf_reg[7:0]};
      2'd1:    ext = {{16{~zext_reg & buf_reg[15]}}, buf_reg[15:0]};
      2'd2:    ext = {8'd0, buf_reg[23:0]};
      default: ext = buf_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      data_reg    <= '0;
      len_reg     <= '0;
      store_reg   <= 1'b0;
      zext_reg    <= 1'b0;
      wa_reg      <= '0;
      we_reg      <= 1'b0;
      i_reg       <= '0;
      buf_reg     <= '0;
      rd_pend_reg <= 1'b0;
      res_o       <= '0;
      wa_o        <= '0;
      we_o        <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (e[4]) begin
            addr_reg    <= res;
            data_reg    <= n;
            len_reg     <= e[3:2];
            store_reg   <= e[1];
            zext_reg    <= e[0];
            wa_reg      <= wa;
            we_reg      <= we;
            i_reg       <= '0;
            buf_reg     <= '0;
            rd_pend_reg <= 1'b0;
            we_o        <= 1'b0;
            state_reg   <= S_BUSY;
          end else begin
            res_o <= res;
            wa_o  <= wa;
            we_o  <= we;
          end
        end
        S_BUSY: begin
          // Capture of the previous read happens regardless of this cycle's grant.
          buf_reg     <= buf_next;
          rd_pend_reg <= beat && !store_reg;
          if (beat) begin
            i_reg <= i_reg + 2'd1;
            if (i_reg == len_reg)
              state_reg <= store_reg ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          buf_reg     <= buf_next;
          rd_pend_reg <= 1'b0;
          state_reg   <= S_DONE;
        end
        default: begin
          res_o     <= store_reg ? addr_reg : ext;
          wa_o      <= wa_reg;
          we_o      <= we_reg & ~store_reg;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem.sv
module tb_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] res, n;
  logic [4:0]  wa, e;
  logic        we;
  logic        stall_req;
  logic [31:0] res_o;
  logic [4:0]  wa_o;
  logic        we_o;

  always #5 clk = ~clk;

  mem_if bus ();

  mem dut (
    .clk(clk), .rst(rst), .res(res), .wa(wa), .we(we), .e(e), .n(n),
    .bus(bus), .stall_req(stall_req), .res_o(res_o), .wa_o(wa_o), .we_o(we_o)
  );

  int total = 0;
  int passed = 0;
  int fails = 0;

  // Byte-addressed reference memory; unknown bytes are filled randomly on first read.
  logic [7:0] mem_model [logic [31:0]];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = 8'($urandom);
    return mem_model[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Non-memory instruction: result appears one cycle later, no stall.
  task automatic pass_thru(input logic [31:0] r, input logic [4:0] w, input logic wv);
    @(posedge clk); #1;
    e = {1'b0, 4'($urandom)}; res = r; wa = w; we = wv;
    @(negedge clk);
    chk("pt_stall", stall_req, 0);
    @(posedge clk); #1;
    e = 5'd0; res = $urandom; wa = 5'($urandom); we = 1'($urandom);
    @(negedge clk);
    chk("pt_res", res_o, r);
    chk("pt_wa", wa_o, w);
    chk("pt_we", we_o, wv);
    $display("pass-through res=%h wa=%0d we=%0b -> res_o=%h", r, w, wv, res_o);
  endtask

  // One load/store. gmask bit c is gnt in cycle c after acceptance (unless rnd_g).
  task automatic do_op(input logic [1:0] len, input logic st, input logic zx,
                       input logic [31:0] addr, input logic [31:0] nn,
                       input logic [4:0] wa_i, input logic we_i,
                       input logic [31:0] gmask, input bit rnd_g);
    int nb;
    int k;
    int lows;
    int stalls;
    bit waited;
    bit done;
    bit din_valid;
    logic [7:0]  din_next;
    logic [7:0]  b [4];
    logic [31:0] exp_res;
    nb = int'(len) + 1;
    k = 0; lows = 0; stalls = 0; waited = 0; done = 0; din_valid = 0; din_next = 8'd0;

    @(posedge clk); #1;
    res = addr; n = nn; wa = wa_i; we = we_i; e = {1'b1, len, st, zx};
    bus.gnt = 1'($urandom); bus.mem_din = 8'($urandom);
    @(negedge clk);
    chk("acc_stall", stall_req, 1);
    chk("acc_wr", bus.mem_wr, 0);
    chk("acc_a", bus.mem_a, 0);
    stalls++;

    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (rnd_g) bus.gnt = (c < 20) ? ($urandom_range(0, 9) < 7) : 1'b1;
      else       bus.gnt = gmask[c];
      bus.mem_din = din_valid ? din_next : 8'($urandom);
      din_valid = 0;
      @(negedge clk);
      if (k < nb) begin
        chk("busy_stall", stall_req, 1);
        chk("busy_a", bus.mem_a, addr + 32'(k));
        stalls++;
        if (bus.gnt) begin
          chk("beat_wr", bus.mem_wr, st);
          chk("beat_dout", bus.mem_dout, st ? 8'(nn >> (8 * k)) : 8'd0);
          if (!st) begin
            din_next = rd_byte(addr + 32'(k));
            din_valid = 1;
          end
          k++;
        end else begin
          chk("hold_wr", bus.mem_wr, 0);
          chk("hold_dout", bus.mem_dout, 0);
          lows++;
        end
      end else if (!st && !waited) begin
        chk("wait_stall", stall_req, 1);
        chk("wait_wr", bus.mem_wr, 0);
        chk("wait_a", bus.mem_a, 0);
        waited = 1;
        stalls++;
      end else begin
        chk("done_stall", stall_req, 0);
        chk("done_wr", bus.mem_wr, 0);
        done = 1;
      end
    end
    chk("op_done", 32'(done), 1);

    for (int j = 0; j < 4; j++) b[j] = (j < nb) ? rd_byte(addr + 32'(j)) : 8'd0;
    if (st) begin
      exp_res = addr;
      for (int j = 0; j < nb; j++) mem_model[addr + 32'(j)] = 8'(nn >> (8 * j));
    end else begin
      case (len)
        2'd0:    exp_res = zx ? {24'd0, b[0]} : 32'($signed(b[0]));
        2'd1:    exp_res = zx ? {16'd0, b[1], b[0]} : 32'($signed({b[1], b[0]}));
        2'd2:    exp_res = {8'd0, b[2], b[1], b[0]};
        default: exp_res = {b[3], b[2], b[1], b[0]};
      endcase
    end

    @(posedge clk); #1;
    e = 5'd0; res = $urandom; wa = 5'($urandom); we = 1'($urandom);
    bus.gnt = 1'($urandom); bus.mem_din = 8'($urandom);
    @(negedge clk);
    chk("wb_res", res_o, exp_res);
    chk("wb_wa", wa_o, wa_i);
    chk("wb_we", we_o, we_i & ~st);
    chk("stall_cycles", 32'(stalls), 32'(nb + (st ? 1 : 2) + lows));
    $display("%s len=%0d zx=%0b addr=%h n=%h -> res_o=%h wa_o=%0d we_o=%0b stalls=%0d",
             st ? "store" : "load ", nb, zx, addr, nn, res_o, wa_o, we_o, stalls);
  endtask

  initial begin
    rst = 1'b1;
    res = 32'hDEAD_BEEF; n = 32'd0; wa = 5'd9; we = 1'b1; e = 5'b1_1100;
    bus.gnt = 1'b1; bus.mem_din = 8'd0;
    #12;
    chk("rst_res", res_o, 0);
    chk("rst_wa", wa_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_wr", bus.mem_wr, 0);
    chk("rst_a", bus.mem_a, 0);
    e = 5'd0;
    @(negedge clk); rst = 1'b0;

    pass_thru(32'h0000_1234, 5'd5, 1'b1);

    // SW 0x100
    do_op(2'd3, 1'b1, 1'b0, 32'h100, 32'hAABB_CCDD, 5'd3, 1'b1, '1, 0);

    // Loads with known memory contents
    mem_model[32'h200] = 8'h80;
    do_op(2'd0, 1'b0, 1'b0, 32'h200, 32'd0, 5'd4, 1'b1, '1, 0);   // LB
    do_op(2'd0, 1'b0, 1'b1, 32'h200, 32'd0, 5'd4, 1'b1, '1, 0);   // LBU
    mem_model[32'h210] = 8'h34; mem_model[32'h211] = 8'h92;
    do_op(2'd1, 1'b0, 1'b0, 32'h210, 32'd0, 5'd6, 1'b1, '1, 0);   // LH
    mem_model[32'h220] = 8'h78; mem_model[32'h221] = 8'h56;
    mem_model[32'h222] = 8'h34; mem_model[32'h223] = 8'h12;
    do_op(2'd3, 1'b0, 1'b0, 32'h220, 32'd0, 5'd7, 1'b1, '1, 0);   // LW
    // LW with the grant withheld for two cycles after the first beat
    do_op(2'd3, 1'b0, 1'b0, 32'h220, 32'd0, 5'd8, 1'b1, 32'hFFFF_FFF9, 0);

    // Asynchronous reset in the middle of a word load
    @(posedge clk); #1;
    res = 32'h300; wa = 5'd10; we = 1'b1; e = 5'b1_1100; bus.gnt = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wr", bus.mem_wr, 0);
    chk("mid_rst_stall", stall_req, 0);
    chk("mid_rst_a", bus.mem_a, 0);
    chk("mid_rst_dout", bus.mem_dout, 0);
    chk("mid_rst_res", res_o, 0);
    chk("mid_rst_wa", wa_o, 0);
    chk("mid_rst_we", we_o, 0);
    $display("reset mid-LW: stall=%0b mem_wr=%0b res_o=%h", stall_req, bus.mem_wr, res_o);
    e = 5'd0;
    @(negedge clk); rst = 1'b0;
    do_op(2'd0, 1'b1, 1'b0, 32'h10, 32'h0000_005A, 5'd11, 1'b1, '1, 0);  // SB

    // Address wrap-around
    do_op(2'd1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_BEEF, 5'd12, 1'b0, '1, 0);
    do_op(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0102_0304, 5'd13, 1'b1, '1, 0);
    do_op(2'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 5'd14, 1'b1, '1, 0);

    // Randomized mix over a small address window so loads read back stores
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0)
        pass_thru($urandom, 5'($urandom), 1'($urandom));
      do_op(2'($urandom), 1'($urandom), 1'($urandom), a, $urandom,
            5'($urandom), 1'($urandom), '0, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
